// File: rtl/alu_flag_pipe.sv
// Two-stage ALU pipeline with valid/ready handshaking and stored carry/zero flags.
// Define ALU_OVERFLOW_FLAG_EN to add the stored signed-overflow flag output v_flag.
module alu_flag_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             flag_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic             v_flag,
`endif
  output logic             z_flag
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADC  = 3'b001,
    OP_NAND = 3'b010,
    OP_SUB  = 3'b011,
    OP_PASS = 3'b100
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  logic             adv;
  logic             accept;
  logic             xfer;

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic             is_arith;
  logic             upd_z;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | adv;
  assign accept   = in_valid & in_ready;
  assign xfer     = s1_valid & adv;

  // ADC reads the live c_flag: a flag committed on the previous edge is already visible here.
  always_comb begin
    b_eff    = s1_b;
    cin      = 1'b0;
    is_arith = 1'b0;
    upd_z    = 1'b0;
    alu_res  = '0;
    case (s1_op)
      OP_ADD: is_arith = 1'b1;
      OP_ADC: begin
        is_arith = 1'b1;
        cin      = c_flag;
      end
      OP_SUB: begin
        is_arith = 1'b1;
        b_eff    = ~s1_b;
        cin      = 1'b1;
      end
      default: ;
    endcase
    sum = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    case (s1_op)
      OP_ADD, OP_ADC, OP_SUB: alu_res = sum[WIDTH-1:0];
      OP_NAND:                alu_res = ~(s1_a & s1_b);
      OP_PASS:                alu_res = s1_a;
      default:                alu_res = '0;
    endcase
    upd_z = is_arith | (s1_op == OP_NAND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_op    <= op_e'(op);
    end else if (xfer) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      result    <= alu_res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Flag clear takes priority over a commit; the result still moves into stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (flag_clr) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (xfer) begin
      if (is_arith) c_flag <= sum[WIDTH];
      if (upd_z)    z_flag <= ~|alu_res;
    end
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  logic v_new;
  assign v_new = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != s1_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_flag <= 1'b0;
    end else if (flag_clr) begin
      v_flag <= 1'b0;
    end else if (xfer && is_arith) begin
      v_flag <= v_new;
    end
  end
`endif

endmodule

// File: tb/tb_alu_flag_pipe.sv
// Directed scoreboard bench for alu_flag_pipe (WIDTH=16); honours ALU_OVERFLOW_FLAG_EN.
module tb_alu_flag_pipe;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic        flag_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        c_flag;
  logic        z_flag;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        v_flag;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic m_c, m_z, m_v;

  alu_flag_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .flag_clr  (flag_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_flag    (c_flag),
`ifdef ALU_OVERFLOW_FLAG_EN
    .v_flag    (v_flag),
`endif
    .z_flag    (z_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic [2:0] mop);
    logic [16:0] s;
    logic [15:0] bb;
    exp_t        e;
    s  = '0;
    bb = (mop == 3'b011) ? ~mb : mb;
    case (mop)
      3'b000: s = {1'b0, ma} + {1'b0, mb};
      3'b001: s = {1'b0, ma} + {1'b0, mb} + {16'd0, m_c};
      3'b011: s = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
      default: ;
    endcase
    case (mop)
      3'b000, 3'b001, 3'b011: begin
        e.res = s[15:0];
        m_c   = s[16];
        m_z   = (s[15:0] == 16'h0000);
        m_v   = (ma[15] == bb[15]) && (s[15] != ma[15]);
      end
      3'b010: begin
        e.res = ~(ma & mb);
        m_z   = (e.res == 16'h0000);
      end
      3'b100:  e.res = ma;
      default: e.res = 16'h0000;
    endcase
    e.c = m_c;
    e.z = m_z;
    e.v = m_v;
    return e;
  endfunction

  // Offer one op; returns cycles until acceptance. clr zeroes the expected flags for it.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic [2:0] top,
                      input logic clr, output int cyc);
    logic got;
    exp_t e;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    op = top;
    cyc = 0;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!got && cyc < 50);
    in_valid = 1'b0;
    if (!got) begin
      chk("accept_timeout", 32'(cyc), 32'd0);
    end else begin
      e = model(ta, tb, top);
      if (clr) begin
        m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
        e.c = 1'b0; e.z = 1'b0; e.v = 1'b0;
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || out_valid) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(result), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("c_flag", 32'(c_flag), 32'(e.c));
        chk("z_flag", 32'(z_flag), 32'(e.z));
`ifdef ALU_OVERFLOW_FLAG_EN
        chk("v_flag", 32'(v_flag), 32'(e.v));
`endif
      end
    end
  end

  initial begin
    int cyc;
    int acc;
    logic took;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
    flag_clr = 1'b0; out_ready = 1'b1;
    m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_c", 32'(c_flag), 32'd0);
    chk("rst_z", 32'(z_flag), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 0x8000+0x8000 wraps to zero with carry
    send(16'h8000, 16'h8000, 3'b000, 1'b0, cyc);
    wait_drain();

    // ADC directly behind ADD picks up the fresh carry
    send(16'h4000, 16'hC000, 3'b000, 1'b0, cyc);
    send(16'h0001, 16'h0001, 3'b001, 1'b0, cyc);
    chk("b2b_adc_cycles", 32'(cyc), 32'd1);
    wait_drain();

    // Signed overflow, then NAND touching z only
    send(16'h7FFF, 16'h0001, 3'b000, 1'b0, cyc);
    send(16'hFFFF, 16'hFFFF, 3'b010, 1'b0, cyc);
    wait_drain();

    // SUB with flag_clr on its stage transfer edge
    send(16'h0005, 16'h0005, 3'b011, 1'b1, cyc);
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    wait_drain();

    // Backpressure: out_ready low for 4 cycles with in_valid held
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 16'h0001; b = 16'h0002; op = 3'b000;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      took = in_ready;
      if (took) begin
        e = model(a, b, op);
        sb.push_back(e);
        acc++;
      end
      @(posedge clk);
      #1;
      if (took) begin
        a = a + 16'h0010;
        b = b + 16'h0100;
      end
    end
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Full-throughput stream over PASS, reserved, NAND, SUB-with-borrow
    send(16'h1234, 16'h5678, 3'b100, 1'b0, cyc);
    send(16'hABCD, 16'h1111, 3'b110, 1'b0, cyc);
    chk("stream_cycles_rsv", 32'(cyc), 32'd1);
    send(16'h0F0F, 16'h00FF, 3'b010, 1'b0, cyc);
    chk("stream_cycles_nand", 32'(cyc), 32'd1);
    send(16'h0003, 16'h0005, 3'b011, 1'b0, cyc);
    chk("stream_cycles_sub", 32'(cyc), 32'd1);
    wait_drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(16'h8000, 16'h8000, 3'b000, 1'b0, cyc);
    send(16'h0001, 16'h0001, 3'b000, 1'b0, cyc);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_c", 32'(c_flag), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_c", 32'(c_flag), 32'd0);
    chk("midrst_z", 32'(z_flag), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("postrst_no_stale", 32'(out_valid), 32'd0);
      chk("postrst_c", 32'(c_flag), 32'd0);
    end

    // Pipeline still works after the flush
    send(16'h0002, 16'h0003, 3'b000, 1'b0, cyc);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
